lcd_panel_drv: RTL and testbench
================================

Name: lcd_panel_drv

Overview:
Downstream stage of the LCD controller. Captures each 16-pixel (4x4) burst from the controller's dataout/output_valid into a double-buffered frame store. Continuously scans the front buffer out to the panel with DE/HS/VS timing. Completed frames swap in only at a frame boundary, so the panel never shows a torn image.

Parameters:
PW, 8, pixel width
COLS, 4, active pixels per row
ROWS, 4, active rows per frame
H_BLANK, 2, blank ticks per row (>=1)
V_BLANK, 1, blank lines per frame (>=1)
DIV, 2, clk cycles per pixel tick (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
pix_in  in  PW  pixel from controller dataout
pix_valid  in  1  pixel strobe, from controller output_valid
pnl_data  out  PW  panel pixel
pnl_de  out  1  data enable, active region
pnl_hs  out  1  line sync
pnl_vs  out  1  frame sync
frame_swap  out  1  1-clk pulse: new frame became front
frame_err  out  1  1-clk pulse: burst aborted short
frame_ovf  out  1  1-clk pulse: completed frame replaced an unshown pending frame

Behaviour:
- Reset: all outputs 0; wr_cnt=0, front=0, pending=0, has_frame=0, tick/h/v counters 0. Buffer RAM is not reset. Reset mid-burst discards the partial frame.
- Capture, every clk:
  - pix_valid=1: back[wr_cnt] <= pix_in, where back bank = ~front. Raster order, index = row*COLS+col.
  - Write with wr_cnt=15: wr_cnt<=0 and pending<=1. If pending was already 1, frame_ovf pulses; newest frame wins.
  - Otherwise wr_cnt increments.
  - pix_valid=0 with wr_cnt!=0: wr_cnt<=0 and frame_err pulses; pending is unchanged.
  - A 17th consecutive valid pixel starts a new burst at index 0.
- Tick: a divider counts 0..DIV-1; tick is true when it equals DIV-1. DIV=1 gives a tick every clk.
- Scan counters advance only on tick:
  - h: 0..COLS+H_BLANK-1, then wraps to 0.
  - v: increments when h wraps; range 0..ROWS+V_BLANK-1, then wraps to 0.
- Outputs are registered, updated every clk from the current (h,v):
  - pnl_de = (h<COLS && v<ROWS).
  - pnl_hs = (h==COLS+H_BLANK-1).
  - pnl_vs = (v==ROWS+V_BLANK-1).
  - pnl_data = front[v*COLS+h] when pnl_de && has_frame; otherwise 0.
  - Latency: each output follows its counter position by 1 clk.
- Swap happens on the tick where h and v are both at their maxima (end of frame). Conditions: pending=1, wr_cnt=0, pix_valid=0. Then front<=~front, pending<=0, has_frame<=1, and frame_swap pulses. If any condition fails, the swap defers to the next frame end and no frame is lost.
- A capture-completion and a swap never coincide: swap requires pix_valid=0.
- Default frame period: (4+2)*(4+1)=30 ticks = 60 clk.

Decomposition:
- Shared package lcd_pkg:
  - PW, COLS, ROWS constants.
  - Pixel typedef.
  - Controller command encodings (LOAD=0 .. SHIFT_DOWN=8) for benches driving the full chain.
- Sub-module lcd_scan_timing:
  - Contains the divider, h/v counters, and DE/HS/VS decode.
  - Exports h, v, and a frame_end strobe.
  - The top level holds the capture logic, the 2x16 buffer, and the swap control.

Test Plan:
- Reset, then no input for 60 clk -> pnl_data=0 throughout; pnl_de high for 16 ticks per frame; pnl_hs high 1 tick per line; pnl_vs high for line 4; no pulses.
- Burst of 16 pixels 0x10..0x1F -> pending set; frame_swap once at the next frame end. Following frame shows 0x10..0x13 on row 0 … 0x1C..0x1F on row 3, each pixel held 2 clk.
- Burst of 7 pixels, then pix_valid low -> frame_err pulses 1 clk; no swap; displayed frame unchanged.
- Two complete bursts (0xA0.., 0xB0..) before any frame end -> frame_ovf pulses once; next frame shows 0xB0..0xBF.
- Burst in progress across the frame end -> swap deferred one frame; no tearing; frame_swap arrives 60 clk later.
- Assert reset at pixel 9 of a burst, release, send a full burst 0x50.. -> only 0x50..0x5F is ever displayed; outputs 0 during reset.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD controller chain.
// Default panel geometry, pixel type, controller command encodings, and a
// small counter-width helper used by the panel driver and its scan timing.
package lcd_pkg;

  localparam int PW   = 8;
  localparam int COLS = 4;
  localparam int ROWS = 4;

  typedef logic [PW-1:0] pixel_t;

  typedef enum logic [3:0] {
    CMD_LOAD        = 4'd0,
    CMD_ROTATE      = 4'd1,
    CMD_MIRROR_X    = 4'd2,
    CMD_MIRROR_Y    = 4'd3,
    CMD_INVERT      = 4'd4,
    CMD_SHIFT_LEFT  = 4'd5,
    CMD_SHIFT_RIGHT = 4'd6,
    CMD_SHIFT_UP    = 4'd7,
    CMD_SHIFT_DOWN  = 4'd8
  } lcd_cmd_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_scan_timing.sv
// Panel scan timing generator.
// A clock divider produces the pixel tick; horizontal and vertical counters
// advance on the tick and wrap over active + blanking. DE/HS/VS are decoded
// from the counters and registered (one clk behind the counter position).
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   o_h, o_v       current horizontal / vertical counter position
//   o_active       combinational: current position is inside the active area
//   o_frame_end    combinational: tick with both counters at their maxima
//   o_de/o_hs/o_vs registered data enable, line sync, frame sync
module lcd_scan_timing #(
  parameter int COLS    = 4,
  parameter int ROWS    = 4,
  parameter int H_BLANK = 2,
  parameter int V_BLANK = 1,
  parameter int DIV     = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  output logic [lcd_pkg::cnt_width(COLS+H_BLANK)-1:0]     o_h,
  output logic [lcd_pkg::cnt_width(ROWS+V_BLANK)-1:0]     o_v,
  output logic                                            o_active,
  output logic                                            o_frame_end,
  output logic                                            o_de,
  output logic                                            o_hs,
  output logic                                            o_vs
);
  import lcd_pkg::*;

  localparam int HT = COLS + H_BLANK;
  localparam int VT = ROWS + V_BLANK;
  localparam int HW = cnt_width(HT);
  localparam int VW = cnt_width(VT);
  localparam int DW = cnt_width(DIV);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_de, r_hs, r_vs;
  logic          w_tick, w_h_last, w_v_last, w_active;

  always_comb begin
    w_tick   = (r_div == DW'(DIV - 1));
    w_h_last = (r_h == HW'(HT - 1));
    w_v_last = (r_v == VW'(VT - 1));
    w_active = (r_h < HW'(COLS)) && (r_v < VW'(ROWS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + VW'(1);
        end else begin
          r_h <= r_h + HW'(1);
        end
      end
      r_de <= w_active;
      r_hs <= w_h_last;
      r_vs <= w_v_last;
    end
  end

  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_active    = w_active;
  assign o_frame_end = w_tick && w_h_last && w_v_last;
  assign o_de        = r_de;
  assign o_hs        = r_hs;
  assign o_vs        = r_vs;

endmodule

// File: rtl/lcd_panel_drv.sv
// LCD panel driver: captures COLS*ROWS-pixel bursts from the controller into
// the back half of a double-buffered frame store and scans the front half
// out to the panel. A completed frame becomes front only at a frame end, so
// the panel never shows a mix of two frames.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pix_in, pix_valid   raster-order pixel stream from the controller
//   pnl_data            panel pixel (0 outside active area or before 1st frame)
//   pnl_de/hs/vs        panel data enable, line sync, frame sync
//   frame_swap          1-clk pulse: pending frame became front
//   frame_err           1-clk pulse: burst ended short and was discarded
//   frame_ovf           1-clk pulse: new frame replaced an unshown pending one
module lcd_panel_drv #(
  parameter int PW      = lcd_pkg::PW,
  parameter int COLS    = lcd_pkg::COLS,
  parameter int ROWS    = lcd_pkg::ROWS,
  parameter int H_BLANK = 2,
  parameter int V_BLANK = 1,
  parameter int DIV     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] pix_in,
  input  logic          pix_valid,
  output logic [PW-1:0] pnl_data,
  output logic          pnl_de,
  output logic          pnl_hs,
  output logic          pnl_vs,
  output logic          frame_swap,
  output logic          frame_err,
  output logic          frame_ovf
);
  import lcd_pkg::*;

  localparam int N  = COLS * ROWS;
  localparam int IW = cnt_width(N);
  localparam int HW = cnt_width(COLS + H_BLANK);
  localparam int VW = cnt_width(ROWS + V_BLANK);

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic          w_active, w_frame_end;

  lcd_scan_timing #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .H_BLANK (H_BLANK),
    .V_BLANK (V_BLANK),
    .DIV     (DIV)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .o_h         (w_h),
    .o_v         (w_v),
    .o_active    (w_active),
    .o_frame_end (w_frame_end),
    .o_de        (pnl_de),
    .o_hs        (pnl_hs),
    .o_vs        (pnl_vs)
  );

  // Bank r_front is displayed; bank ~r_front receives the incoming burst.
  logic [PW-1:0] r_mem [2][N];
  logic [IW-1:0] r_wr_cnt;
  logic          r_front, r_pending, r_has_frame;
  logic          r_swap, r_err, r_ovf;
  logic [PW-1:0] r_data;
  logic [IW-1:0] w_rd_idx;
  logic          w_last_px, w_swap_ok;

  always_comb begin
    w_last_px = (r_wr_cnt == IW'(N - 1));
    // Swap needs pix_valid low, so it can never coincide with a completion.
    w_swap_ok = w_frame_end && r_pending && (r_wr_cnt == '0) && !pix_valid;
    w_rd_idx  = '0;
    if (w_active) w_rd_idx = IW'(int'(w_v) * COLS + int'(w_h));
  end

  // Frame store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (pix_valid) r_mem[~r_front][r_wr_cnt] <= pix_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_cnt    <= '0;
      r_front     <= 1'b0;
      r_pending   <= 1'b0;
      r_has_frame <= 1'b0;
      r_swap      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_swap <= 1'b0;
      r_err  <= 1'b0;
      r_ovf  <= 1'b0;
      if (pix_valid) begin
        if (w_last_px) begin
          r_wr_cnt  <= '0;
          r_pending <= 1'b1;
          r_ovf     <= r_pending;
        end else begin
          r_wr_cnt <= r_wr_cnt + IW'(1);
        end
      end else if (r_wr_cnt != '0) begin
        r_wr_cnt <= '0;
        r_err    <= 1'b1;
      end
      if (w_swap_ok) begin
        r_front     <= ~r_front;
        r_pending   <= 1'b0;
        r_has_frame <= 1'b1;
        r_swap      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_data <= '0;
    else       r_data <= (w_active && r_has_frame) ? r_mem[r_front][w_rd_idx] : '0;
  end

  assign pnl_data   = r_data;
  assign frame_swap = r_swap;
  assign frame_err  = r_err;
  assign frame_ovf  = r_ovf;

endmodule

// File: tb/tb_lcd_panel_drv.sv
// Directed bench for lcd_panel_drv with default geometry (4x4, H_BLANK=2,
// V_BLANK=1, DIV=2): one frame = 30 ticks = 60 clk. Expected scan outputs
// after clock edge n (counted from reset release) come from position k=n-1:
// tick t=k/2, h=t%6, v=(t/6)%5. Frame ends / swaps land on n = 60*m.
module tb_lcd_panel_drv;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] pnl_data;
  logic       pnl_de, pnl_hs, pnl_vs, frame_swap, frame_err, frame_ovf;

  int total = 0, bad = 0;
  int cyc = 0;
  int sw_cnt = 0, err_cnt = 0, ovf_cnt = 0, last_sw = -1;

  lcd_panel_drv #(
    .PW(8), .COLS(4), .ROWS(4), .H_BLANK(2), .V_BLANK(1), .DIV(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pnl_data   (pnl_data),
    .pnl_de     (pnl_de),
    .pnl_hs     (pnl_hs),
    .pnl_vs     (pnl_vs),
    .frame_swap (frame_swap),
    .frame_err  (frame_err),
    .frame_ovf  (frame_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_swap) begin sw_cnt++; last_sw = cyc; end
      if (frame_err) err_cnt++;
      if (frame_ovf) ovf_cnt++;
    end
  end

  task automatic send_px(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(base + i);
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  // Advance to the next negedge where cyc is a multiple of 60 (frame boundary).
  task automatic wait_frame_start(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!((cyc % 60) == 0 && cyc != 0) && n < 200);
    if (n >= 200) begin
      bad++; total++;
      $display("FAIL %s_frame_wait: got no boundary in %0d clk, want <200", tag, n);
    end
  endtask

  // Check every scan output each clk until the next frame boundary.
  task automatic scan_frame(input string tag, input int base, input bit has);
    int n = 0;
    int k, t, h, v;
    logic ede, ehs, evs;
    logic [7:0] ed;
    do begin
      @(negedge clk); n++;
      k = cyc - 1; t = k / 2; h = t % 6; v = (t / 6) % 5;
      ede = (h < 4) && (v < 4);
      ehs = (h == 5);
      evs = (v == 4);
      ed  = (ede && has) ? 8'(base + v * 4 + h) : 8'h00;
      total += 4;
      if (pnl_de !== ede) begin bad++; $display("FAIL %s_de cyc=%0d got=%b want=%b", tag, cyc, pnl_de, ede); end
      if (pnl_hs !== ehs) begin bad++; $display("FAIL %s_hs cyc=%0d got=%b want=%b", tag, cyc, pnl_hs, ehs); end
      if (pnl_vs !== evs) begin bad++; $display("FAIL %s_vs cyc=%0d got=%b want=%b", tag, cyc, pnl_vs, evs); end
      if (pnl_data !== ed) begin bad++; $display("FAIL %s_data cyc=%0d got=%h want=%h", tag, cyc, pnl_data, ed); end
    end while ((cyc % 60) != 0 && n < 70);
    if (n >= 70) begin
      bad++; total++;
      $display("FAIL %s_scan_bound: got %0d clk, want <=60", tag, n);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total += 7;
    if (pnl_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", pnl_data); end
    if (pnl_de !== 1'b0) begin bad++; $display("FAIL rst_de got=%b want=0", pnl_de); end
    if (pnl_hs !== 1'b0) begin bad++; $display("FAIL rst_hs got=%b want=0", pnl_hs); end
    if (pnl_vs !== 1'b0) begin bad++; $display("FAIL rst_vs got=%b want=0", pnl_vs); end
    if (frame_swap !== 1'b0) begin bad++; $display("FAIL rst_swap got=%b want=0", frame_swap); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", frame_err); end
    if (frame_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", frame_ovf); end
    reset = 1'b0;
  endtask

  task automatic test_idle;
    scan_frame("idle", 0, 1'b0);
    total += 3;
    if (sw_cnt !== 0) begin bad++; $display("FAIL idle_swap got=%0d want=0", sw_cnt); end
    if (err_cnt !== 0) begin bad++; $display("FAIL idle_err got=%0d want=0", err_cnt); end
    if (ovf_cnt !== 0) begin bad++; $display("FAIL idle_ovf got=%0d want=0", ovf_cnt); end
  endtask

  task automatic test_burst;
    int fs, sw0;
    wait_frame_start("burst");
    fs = cyc; sw0 = sw_cnt;
    send_px(8'h10, 16);
    wait_frame_start("burst");
    scan_frame("burst", 8'h10, 1'b1);
    total += 2;
    if (sw_cnt - sw0 !== 1) begin bad++; $display("FAIL burst_swap_cnt got=%0d want=1", sw_cnt - sw0); end
    if (last_sw !== fs + 60) begin bad++; $display("FAIL burst_swap_cyc got=%0d want=%0d", last_sw, fs + 60); end
  endtask

  task automatic test_abort;
    int sw0, er0;
    wait_frame_start("abort");
    sw0 = sw_cnt; er0 = err_cnt;
    send_px(8'h60, 7);
    repeat (3) @(negedge clk);
    total += 1;
    if (err_cnt - er0 !== 1) begin bad++; $display("FAIL abort_err_cnt got=%0d want=1", err_cnt - er0); end
    wait_frame_start("abort");
    scan_frame("abort", 8'h10, 1'b1);
    total += 1;
    if (sw_cnt - sw0 !== 0) begin bad++; $display("FAIL abort_swap_cnt got=%0d want=0", sw_cnt - sw0); end
  endtask

  task automatic test_back_to_back;
    int fs, sw0, er0, ov0;
    wait_frame_start("b2b");
    fs = cyc; sw0 = sw_cnt; er0 = err_cnt; ov0 = ovf_cnt;
    send_px(8'hA0, 16);
    send_px(8'hB0, 16);
    repeat (2) @(negedge clk);
    total += 2;
    if (ovf_cnt - ov0 !== 1) begin bad++; $display("FAIL b2b_ovf_cnt got=%0d want=1", ovf_cnt - ov0); end
    if (err_cnt - er0 !== 0) begin bad++; $display("FAIL b2b_err_cnt got=%0d want=0", err_cnt - er0); end
    wait_frame_start("b2b");
    scan_frame("b2b", 8'hB0, 1'b1);
    total += 2;
    if (sw_cnt - sw0 !== 1) begin bad++; $display("FAIL b2b_swap_cnt got=%0d want=1", sw_cnt - sw0); end
    if (last_sw !== fs + 60) begin bad++; $display("FAIL b2b_swap_cyc got=%0d want=%0d", last_sw, fs + 60); end
  endtask

  task automatic test_deferred;
    int fs, sw0;
    wait_frame_start("defer");
    fs = cyc; sw0 = sw_cnt;
    repeat (50) @(negedge clk);
    send_px(8'hC0, 16);
    // Rest of the frame spanning the burst must still show the old image.
    scan_frame("defer_old", 8'hB0, 1'b1);
    scan_frame("defer_new", 8'hC0, 1'b1);
    total += 2;
    if (sw_cnt - sw0 !== 1) begin bad++; $display("FAIL defer_swap_cnt got=%0d want=1", sw_cnt - sw0); end
    if (last_sw !== fs + 120) begin bad++; $display("FAIL defer_swap_cyc got=%0d want=%0d", last_sw, fs + 120); end
  endtask

  task automatic test_reset_mid;
    int sw0, er0;
    wait_frame_start("rstmid");
    for (int i = 0; i < 9; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(8'h90 + i);
      @(negedge clk);
    end
    reset = 1'b1;
    pix_valid = 1'b0;
    #1;
    total += 4;
    if (pnl_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", pnl_data); end
    if (pnl_de !== 1'b0) begin bad++; $display("FAIL rstmid_de got=%b want=0", pnl_de); end
    if (pnl_hs !== 1'b0) begin bad++; $display("FAIL rstmid_hs got=%b want=0", pnl_hs); end
    if (pnl_vs !== 1'b0) begin bad++; $display("FAIL rstmid_vs got=%b want=0", pnl_vs); end
    repeat (2) @(negedge clk);
    total += 1;
    if (pnl_data !== 8'h00) begin bad++; $display("FAIL rstmid_hold_data got=%h want=00", pnl_data); end
    reset = 1'b0;
    sw0 = sw_cnt; er0 = err_cnt;
    scan_frame("rstmid_blank0", 0, 1'b0);
    send_px(8'h50, 16);
    scan_frame("rstmid_blank1", 0, 1'b0);
    scan_frame("rstmid_new", 8'h50, 1'b1);
    total += 3;
    if (sw_cnt - sw0 !== 1) begin bad++; $display("FAIL rstmid_swap_cnt got=%0d want=1", sw_cnt - sw0); end
    if (last_sw !== 120) begin bad++; $display("FAIL rstmid_swap_cyc got=%0d want=120", last_sw); end
    if (err_cnt - er0 !== 0) begin bad++; $display("FAIL rstmid_err_cnt got=%0d want=0", err_cnt - er0); end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_burst;
    test_abort;
    test_back_to_back;
    test_deferred;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
